// File: rtl/stoch_div_arb.sv
// Round-robin arbiter that time-shares one stochastic divider: clear, warm up, then count y=1 over SAMPLES cycles.
// Optional macro STOCH_DIV_ARB_ABORT_EN: a requester dropping req mid-job aborts it and pulses abort_pulse.
module stoch_div_arb #(
  parameter int NREQ    = 4,
  parameter int WARMUP  = 16,
  parameter int SAMPLES = 256,
  parameter int CNT_W   = $clog2(SAMPLES+1),
  parameter int ID_W    = $clog2(NREQ)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  a,
  input  logic [NREQ-1:0]  b,
  output logic [NREQ-1:0]  grant,
  output logic             div_nrst,
  output logic             div_a,
  output logic             div_b,
  input  logic             div_y,
  output logic             done_valid,
  output logic [ID_W-1:0]  done_id,
  output logic [CNT_W-1:0] done_count,
`ifdef STOCH_DIV_ARB_ABORT_EN
  output logic             abort_pulse,
`endif
  input  logic             done_ready
);

  localparam int TMAX  = (SAMPLES > WARMUP) ? SAMPLES : WARMUP;
  localparam int TMR_W = $clog2(TMAX+1);
  localparam logic [TMR_W-1:0] WARM_LAST = TMR_W'((WARMUP > 0) ? WARMUP-1 : 0);
  localparam logic [TMR_W-1:0] RUN_LAST  = TMR_W'(SAMPLES-1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WARM, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  gid_q, gid_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ID_W-1:0]  pick, rr_next;
  logic             req_gid;
  int               best, off;

  // Winner is the set request with the smallest wrapped distance from rr.
  always_comb begin
    pick = '0;
    best = NREQ;
    off  = 0;
    for (int j = 0; j < NREQ; j++) begin
      if (req[j]) begin
        off = (j - int'(rr_q) + NREQ) % NREQ;
        if (off < best) begin
          best = off;
          pick = ID_W'(j);
        end
      end
    end
  end

  // gid is always < NREQ; unmatched index falls through to 0.
  always_comb begin
    div_a   = 1'b0;
    div_b   = 1'b0;
    req_gid = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (gid_q == ID_W'(j)) begin
        div_a   = a[j] & (|grant_q);
        div_b   = b[j] & (|grant_q);
        req_gid = req[j];
      end
    end
  end

  assign rr_next = (gid_q == ID_W'(NREQ-1)) ? '0 : gid_q + 1'b1;

`ifdef STOCH_DIV_ARB_ABORT_EN
  logic abort_q, abort_d;
`endif

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    timer_d = timer_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gid_d   = pick;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        timer_d = '0;
        count_d = '0;
        state_d = (WARMUP == 0) ? S_RUN : S_WARM;
      end
      S_WARM: begin
        if (timer_q == WARM_LAST) begin
          timer_d = '0;
          state_d = S_RUN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RUN: begin
        count_d = count_q + CNT_W'(div_y);
        if (timer_q == RUN_LAST) begin
          timer_d = '0;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        if (done_ready) begin
          grant_d = '0;
          rr_d    = rr_next;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef STOCH_DIV_ARB_ABORT_EN
    abort_d = 1'b0;
    // DONE is excluded: a finished result is always delivered.
    if ((state_q == S_CLEAR || state_q == S_WARM || state_q == S_RUN) && !req_gid) begin
      state_d = S_IDLE;
      grant_d = '0;
      rr_d    = rr_next;
      abort_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      gid_q   <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      timer_q <= '0;
      count_q <= '0;
`ifdef STOCH_DIV_ARB_ABORT_EN
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      timer_q <= timer_d;
      count_q <= count_d;
`ifdef STOCH_DIV_ARB_ABORT_EN
      abort_q <= abort_d;
`endif
    end
  end

`ifdef STOCH_DIV_ARB_ABORT_EN
  assign abort_pulse = abort_q;
`endif

  assign grant      = grant_q;
  assign div_nrst   = (state_q == S_WARM) || (state_q == S_RUN) || (state_q == S_DONE);
  assign done_valid = (state_q == S_DONE);
  assign done_id    = gid_q;
  assign done_count = count_q;

endmodule

// File: doc/stoch_div_arb.md
Name: stoch_div_arb

Overview:
- Shares one stochastic divider instance (y = a/b, signed saturating internal counter, LFSR comparator) among NREQ requesters.
- Per job: arbitrate, clear the divider through its reset, discard WARMUP cycles of output while the divider counter settles, then count '1' bits of y over SAMPLES cycles.
- Returns the count to the winning requester through a valid/ready result port.
- Sits between the bitstream generators and the shared divider, which is instantiated by the parent and wired to the div_* ports.

Parameters:
NREQ, 4, number of requesters (2..16)
WARMUP, 16, output cycles discarded after divider clear (0 allowed)
SAMPLES, 256, output cycles counted per job (>=1)
CNT_W, $clog2(SAMPLES+1), result count width
ID_W, $clog2(NREQ), requester index width

Ports:
CLK  in  1  clock, all logic on posedge
nRST  in  1  synchronous active-low reset
req  in  NREQ  per-requester job request, level, held until result accepted
a  in  NREQ  per-requester dividend bitstream
b  in  NREQ  per-requester divisor bitstream
grant  out  NREQ  one-hot, registered; high from CLEAR through DONE
div_nrst  out  1  divider synchronous reset, active low
div_a  out  1  a[gid] when granted, else 0 (combinational mux on registered gid)
div_b  out  1  b[gid] when granted, else 0
div_y  in  1  divider output bit
done_valid  out  1  result valid
done_id  out  ID_W  requester index of result
done_count  out  CNT_W  number of div_y=1 cycles in RUN
done_ready  in  1  result accepted

Behaviour:
- Reset (nRST=0 at posedge):
  - state=IDLE, grant=0, done_valid=0, done_id=0, done_count=0.
  - rr pointer=0, timer=0, div_nrst=0.
  - Reset mid-job abandons the job silently.
- div_nrst=0 in IDLE and CLEAR, 1 in WARM, RUN and DONE. The divider is always started from a clean state.
- FSM:
  - IDLE: if req!=0, select the first set bit searching upward from rr with wrap (rr, rr+1, ..., NREQ-1, 0, ...). Register gid and set grant. -> CLEAR.
  - CLEAR: one cycle; timer=0, count=0. -> WARM, or -> RUN if WARMUP==0.
  - WARM: div_a/div_b driven, div_y ignored; timer counts 0..WARMUP-1. -> RUN on the last cycle, timer reset to 0.
  - RUN: count += div_y each cycle; timer counts 0..SAMPLES-1. -> DONE on the last cycle, including that cycle's div_y.
  - DONE: done_valid=1; done_id and done_count stable while done_valid=1 && done_ready=0. On done_valid && done_ready: grant=0, rr=(gid+1) mod NREQ, -> IDLE.
- Latency: req seen in IDLE at cycle t -> grant at t+1 -> done_valid at t+2+WARMUP+SAMPLES (t+274 at defaults).
- Count width: the count never exceeds SAMPLES, so no overflow; done_count=SAMPLES is legal.
- Requests arriving while busy wait; no queueing beyond the req level.
- A new arbitration happens only in IDLE. There is a minimum one IDLE cycle between jobs.
- Out-of-range gid is impossible; the mux default is 0.

Optional Feature:
- Macro: STOCH_DIV_ARB_ABORT_EN.
- Defined: if req[gid] falls during CLEAR, WARM or RUN:
  - Next cycle: -> IDLE, grant=0, rr=(gid+1) mod NREQ, no done_valid.
  - abort_pulse (extra 1-bit output port, present only when defined) =1 for that one cycle.
  - A req drop in DONE is ignored; the result still waits for done_ready.
- Undefined: req level is ignored after grant; the job always runs to DONE and the result is delivered.

Test Plan:
- Single job: req=4'b0001, bench drives div_y=1 constantly -> grant=0001 at t+1; div_nrst low through CLEAR, high from t+2; done_valid at t+274 with done_id=0, done_count=256.
- Count gating: div_y=1 only during cycles t+2..t+17 (WARM), 0 afterwards -> done_count=0. div_y toggling 1,0 starting at the first RUN cycle -> done_count=128.
- Round-robin: req=4'b1111 held, done_ready=1 -> grant order 0001, 0010, 0100, 1000, 0001; done_id sequence 0,1,2,3,0.
- Backpressure: done_ready=0 for 50 cycles in DONE -> done_valid, done_id and done_count stable; no new grant; single handshake on the cycle done_ready=1.
- Reset mid-RUN: nRST=0 at timer=100 -> next cycle grant=0, done_valid=0, state IDLE; rerun yields a full 256-sample count.
- With the real divider, a=b=all ones, STOCH_DIV_ARB_ABORT_EN: complete job gives done_count>=230. Dropping req[gid] at RUN cycle 10 gives abort_pulse=1 for one cycle, no done_valid, and the next requester is granted.
